// File: rtl/qoi_chunk_encoder.sv
// qoi_chunk_encoder: streaming QOI chunk encoder.
// Takes one RGBA pixel per handshake and emits the QOI chunk byte stream,
// one byte per handshake. Header and end marker are produced elsewhere.
// The 64-entry colour index is held in flops because it must be cleared
// in a single cycle whenever a new image starts.

module qoi_chunk_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] npix,
    input  logic        pix_valid,
    input  logic [31:0] pix_rgba,
    output logic        pix_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_EMIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Opaque black: the implicit "previous pixel" at the start of an image.
    localparam logic [31:0] PREV_INIT = 32'h0000_00FF;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;          // pixels still to accept
    logic        last_q, last_d;        // current chunk belongs to the final pixel
    logic [31:0] prev_q, prev_d;
    logic [5:0]  run_q, run_d;
    logic [31:0] index_q [64];
    logic [31:0] index_d [64];
    logic [7:0]  queue_q [6];           // queue_q[0] is the byte on out_data
    logic [7:0]  queue_d [6];
    logic [2:0]  qcnt_q, qcnt_d;
    logic        pix_ready_q, pix_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // ------------------------------------------------------------------
    // Classification signals
    // ------------------------------------------------------------------
    logic [7:0]  px_r, px_g, px_b, px_a;
    logic [7:0]  pv_r, pv_g, pv_b, pv_a;
    logic [7:0]  dr, dg, db;
    logic [7:0]  dr2, dg2, db2, dg32;
    logic [8:0]  drg8, dbg8;
    logic [12:0] hsum;
    logic [5:0]  h;
    logic        diff_ok, luma_ok, alpha_eq, is_same, idx_hit, last_px;
    logic [5:0]  run_inc;

    logic [7:0]  ch [5];                // chunk bytes that follow an optional RUN byte
    logic [2:0]  ch_len;
    logic        run_flag;
    logic [7:0]  run_byte;
    logic [5:0]  run_after;

    // Pixel deltas, range tests and hash for the pixel on pix_rgba.
    always_comb begin
        {px_r, px_g, px_b, px_a} = pix_rgba;
        {pv_r, pv_g, pv_b, pv_a} = prev_q;
        dr = px_r - pv_r;
        dg = px_g - pv_g;
        db = px_b - pv_b;
        // Biasing makes the signed range tests a check of the high bits being zero.
        dr2  = dr + 8'd2;
        dg2  = dg + 8'd2;
        db2  = db + 8'd2;
        dg32 = dg + 8'd32;
        drg8 = {dr[7], dr} - {dg[7], dg} + 9'd8;
        dbg8 = {db[7], db} - {dg[7], dg} + 9'd8;
        diff_ok  = (dr2[7:2] == 6'd0) && (dg2[7:2] == 6'd0) && (db2[7:2] == 6'd0);
        luma_ok  = (dg32[7:6] == 2'd0) && (drg8[8:4] == 5'd0) && (dbg8[8:4] == 5'd0);
        alpha_eq = (px_a == pv_a);
        hsum = 13'd3 * {5'd0, px_r} + 13'd5 * {5'd0, px_g}
             + 13'd7 * {5'd0, px_b} + 13'd11 * {5'd0, px_a};
        h        = 6'(hsum % 13'd64);
        idx_hit  = (index_q[h] == pix_rgba);
        is_same  = (pix_rgba == prev_q);
        run_inc  = run_q + 6'd1;
        last_px  = (cnt_q == 16'd1);
    end

    // Chunk selection: optional RUN byte first, then at most one pixel chunk.
    always_comb begin
        // NOTE: every variable gets a default before the branches so no latch is inferred.
        run_flag  = 1'b0;
        run_byte  = 8'h00;
        run_after = 6'd0;
        ch_len    = 3'd0;
        for (int i = 0; i < 5; i++) ch[i] = 8'h00;

        if (is_same) begin
            if (run_inc == 6'd62 || last_px) begin
                run_flag = 1'b1;
                run_byte = 8'hC0 | {2'b00, run_inc - 6'd1};
            end else begin
                run_after = run_inc;
            end
        end else begin
            if (run_q != 6'd0) begin
                run_flag = 1'b1;
                run_byte = 8'hC0 | {2'b00, run_q - 6'd1};
            end
            if (idx_hit) begin
                ch[0]  = {2'b00, h};
                ch_len = 3'd1;
            end else if (alpha_eq && diff_ok) begin
                ch[0]  = {2'b01, dr2[1:0], dg2[1:0], db2[1:0]};
                ch_len = 3'd1;
            end else if (alpha_eq && luma_ok) begin
                ch[0]  = {2'b10, dg32[5:0]};
                ch[1]  = {drg8[3:0], dbg8[3:0]};
                ch_len = 3'd2;
            end else if (alpha_eq) begin
                ch[0]  = 8'hFE;
                ch[1]  = px_r;
                ch[2]  = px_g;
                ch[3]  = px_b;
                ch_len = 3'd4;
            end else begin
                ch[0]  = 8'hFF;
                ch[1]  = px_r;
                ch[2]  = px_g;
                ch[3]  = px_b;
                ch[4]  = px_a;
                ch_len = 3'd5;
            end
        end
    end

    // Next-state logic for the FSM, datapath registers and registered outputs.
    always_comb begin
        // NOTE: blocking assignments here; qcnt_d is read back after being set below.
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        prev_d      = prev_q;
        run_d       = run_q;
        qcnt_d      = qcnt_q;
        pix_ready_d = pix_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = done_q;
        for (int i = 0; i < 64; i++) index_d[i] = index_q[i];
        for (int i = 0; i < 6; i++)  queue_d[i] = queue_q[i];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_ACCEPT;
                    cnt_d       = npix;
                    last_d      = 1'b0;
                    prev_d      = PREV_INIT;
                    run_d       = 6'd0;
                    qcnt_d      = 3'd0;
                    pix_ready_d = 1'b1;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    for (int i = 0; i < 64; i++) index_d[i] = 32'h0;
                    for (int i = 0; i < 6; i++)  queue_d[i] = 8'h00;
                end
            end

            S_ACCEPT: begin
                if (pix_valid) begin
                    cnt_d  = cnt_q - 16'd1;
                    last_d = last_px;
                    prev_d = pix_rgba;
                    run_d  = run_after;
                    if (!is_same) index_d[h] = pix_rgba;
                    if (run_flag) begin
                        queue_d[0] = run_byte;
                        for (int i = 0; i < 5; i++) queue_d[i + 1] = ch[i];
                    end else begin
                        for (int i = 0; i < 5; i++) queue_d[i] = ch[i];
                        queue_d[5] = 8'h00;
                    end
                    qcnt_d = ch_len + {2'b00, run_flag};
                    if (qcnt_d != 3'd0) begin
                        state_d     = S_EMIT;
                        pix_ready_d = 1'b0;
                        out_valid_d = 1'b1;
                    end else if (last_px) begin
                        state_d     = S_DONE;
                        pix_ready_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end

            S_EMIT: begin
                if (out_ready) begin
                    // Shift in zeros so out_data idles at 0 once the queue drains.
                    for (int i = 0; i < 5; i++) queue_d[i] = queue_q[i + 1];
                    queue_d[5] = 8'h00;
                    qcnt_d     = qcnt_q - 3'd1;
                    if (qcnt_q == 3'd1) begin
                        out_valid_d = 1'b0;
                        if (last_q) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d     = S_ACCEPT;
                            pix_ready_d = 1'b1;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            last_q      <= 1'b0;
            prev_q      <= 32'h0;
            run_q       <= 6'd0;
            qcnt_q      <= 3'd0;
            pix_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            // NOTE: the index is a flop array, not a RAM, so it can be reset like any register.
            for (int i = 0; i < 64; i++) index_q[i] <= 32'h0;
            for (int i = 0; i < 6; i++)  queue_q[i] <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            qcnt_q      <= qcnt_d;
            pix_ready_q <= pix_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int i = 0; i < 64; i++) index_q[i] <= index_d[i];
            for (int i = 0; i < 6; i++)  queue_q[i] <= queue_d[i];
        end
    end

    assign pix_ready = pix_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = queue_q[0];
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_qoi_chunk_encoder.sv
// tb_qoi_chunk_encoder: table-driven directed bench for qoi_chunk_encoder.
// Each record gives an image (up to three distinct pixels, the last one
// repeated to fill npix), the expected chunk bytes and the expected number
// of cycles from the first pix_ready cycle until done is seen.

module tb_qoi_chunk_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] npix;
    logic        pix_valid;
    logic [31:0] pix_rgba;
    logic        pix_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int BUDGET = 500;

    typedef struct {
        int             npix;
        logic [0:2][31:0] px;
        int             nb;
        logic [0:8][7:0]  exp_bytes;
        int             stall_at;    // loop cycle where out_ready drops for 3 cycles, -1 none
        int             cycles;
    } vec_t;

    vec_t vecs [6];

    qoi_chunk_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .npix      (npix),
        .pix_valid (pix_valid),
        .pix_rgba  (pix_rgba),
        .pix_ready (pix_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Encode one image; pix_valid is held high whenever a pixel remains so
    // the DUT must ignore it outside ACCEPT.
    task automatic run_vec(input int id, input vec_t v);
        logic [7:0] got [$];
        int         pi;
        int         cyc;
        bit         both_hi;
        bit         unstable;
        bit         busy_low;
        bit         stalled_prev;
        logic [7:0] held;
        logic [31:0] act;

        got.delete();
        pi = 0; cyc = 0;
        both_hi = 0; unstable = 0; busy_low = 0; stalled_prev = 0; held = 8'h00;

        @(negedge clk);
        start = 1'b1;
        npix  = v.npix[15:0];
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d_busy_after_start", id), {31'd0, busy}, 32'd1);
        check($sformatf("v%0d_ready_after_start", id), {31'd0, pix_ready}, 32'd1);

        while (!done && cyc < BUDGET) begin
            if (pix_ready && out_valid) both_hi = 1;
            if (!busy) busy_low = 1;
            if (stalled_prev && (!out_valid || out_data !== held)) unstable = 1;
            pix_valid = (pi < v.npix);
            pix_rgba  = v.px[(pi < 2) ? pi : 2];
            out_ready = !(v.stall_at >= 0 && cyc >= v.stall_at && cyc < v.stall_at + 3);
            if (pix_ready && pix_valid) pi++;
            if (out_valid && out_ready) got.push_back(out_data);
            stalled_prev = out_valid && !out_ready;
            held = out_data;
            @(negedge clk);
            cyc++;
        end
        pix_valid = 1'b0;
        out_ready = 1'b1;

        check($sformatf("v%0d_done", id), {31'd0, done}, 32'd1);
        check($sformatf("v%0d_busy_in_done", id), {31'd0, busy}, 32'd0);
        check($sformatf("v%0d_cycles", id), cyc, v.cycles);
        check($sformatf("v%0d_pixels_taken", id), pi, v.npix);
        check($sformatf("v%0d_byte_count", id), got.size(), v.nb);
        for (int i = 0; i < v.nb; i++) begin
            act = (i < got.size()) ? {24'd0, got[i]} : 32'hDEAD;
            check($sformatf("v%0d_byte%0d", id, i), act, {24'd0, v.exp_bytes[i]});
        end
        check($sformatf("v%0d_ready_valid_overlap", id), {31'd0, both_hi}, 32'd0);
        check($sformatf("v%0d_stall_stability", id), {31'd0, unstable}, 32'd0);
        check($sformatf("v%0d_busy_held", id), {31'd0, busy_low}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{npix: 1, px: {32'h000000FF, 32'h000000FF, 32'h000000FF},
                    nb: 1, exp_bytes: {8'hC0, 64'd0}, stall_at: -1, cycles: 2};
        vecs[1] = '{npix: 3, px: {32'h0A141EFF, 32'h0B131FFF, 32'h0B131FFF},
                    nb: 6, exp_bytes: {8'hFE, 8'h0A, 8'h14, 8'h1E, 8'h77, 8'hC0, 24'd0},
                    stall_at: -1, cycles: 9};
        vecs[2] = '{npix: 1, px: {32'h14100CFF, 32'h14100CFF, 32'h14100CFF},
                    nb: 2, exp_bytes: {8'hB0, 8'hC4, 56'd0}, stall_at: -1, cycles: 3};
        vecs[3] = '{npix: 64, px: {32'h000000FF, 32'h000000FF, 32'h000000FF},
                    nb: 2, exp_bytes: {8'hFD, 8'hC1, 56'd0}, stall_at: -1, cycles: 66};
        vecs[4] = '{npix: 3, px: {32'h0A141EFF, 32'hC86432FF, 32'h0A141EFF},
                    nb: 9, exp_bytes: {8'hFE, 8'h0A, 8'h14, 8'h1E, 8'hFE, 8'hC8, 8'h64, 8'h32, 8'h09},
                    stall_at: -1, cycles: 12};
        vecs[5] = '{npix: 1, px: {32'h01020380, 32'h01020380, 32'h01020380},
                    nb: 5, exp_bytes: {8'hFF, 8'h01, 8'h02, 8'h03, 8'h80, 32'd0},
                    stall_at: 2, cycles: 9};

        rst = 1'b1; start = 1'b0; npix = 16'd0;
        pix_valid = 1'b0; pix_rgba = 32'h0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset while a chunk is being emitted, then re-encode the same image.
        @(negedge clk);
        start = 1'b1;
        npix  = 16'd3;
        @(negedge clk);
        start     = 1'b0;
        pix_valid = 1'b1;
        pix_rgba  = vecs[1].px[0];
        out_ready = 1'b0;
        @(negedge clk);
        pix_valid = 1'b0;
        check("mid_first_byte_valid", {31'd0, out_valid}, 32'd1);
        check("mid_first_byte", {24'd0, out_data}, 32'hFE);
        check("mid_ready_low", {31'd0, pix_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_pix_ready", {31'd0, pix_ready}, 32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_data", {24'd0, out_data}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        run_vec(6, vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
